// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, NZCV flags,
// an internal accumulator and a tag that travels alongside each operation.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] acc_value
);

  localparam int SW = $clog2(WIDTH);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge, and ready may
  // depend combinationally on the downstream ready but never on valid.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic [3:0]       s1_flags;
  logic             s1_err;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] acc;

  logic s2_load;
  logic accept;

  assign s2_load   = !out_valid || out_ready;
  assign in_ready  = !rst && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  assign acc_value = acc;

  logic [WIDTH-1:0]        a_eff;
  logic [SW-1:0]           sh;
  logic [WIDTH:0]          sum_w;
  logic [WIDTH:0]          dif_w;
  logic [WIDTH:0]          shl_w;
  logic [WIDTH:0]          shr_w;
  logic signed [WIDTH:0]   sra_w;
  logic [WIDTH-1:0]        c_res;
  logic                    c_c;
  logic                    c_v;
  logic                    c_err;
  logic [3:0]              c_flags;

  always_comb begin
    a_eff = in_acc ? acc : in_a;
    sh    = in_b[SW-1:0];
    sum_w = {1'b0, a_eff} + {1'b0, in_b};
    // Bit WIDTH of the widened difference is the unsigned borrow.
    dif_w = {1'b0, a_eff} - {1'b0, in_b};
    // Shifting through a spare bit leaves the last bit shifted out in that spare
    // position, and leaves it 0 for a zero shift amount.
    shl_w = {1'b0, a_eff} << sh;
    shr_w = {a_eff, 1'b0} >> sh;
    sra_w = $signed({a_eff, 1'b0}) >>> sh;
    c_res = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_err = 1'b0;
    case (in_op)
      4'd0: begin
        c_res = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        c_v   = (a_eff[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != a_eff[WIDTH-1]);
      end
      4'd1: begin
        c_res = dif_w[WIDTH-1:0];
        c_c   = dif_w[WIDTH];
        c_v   = (a_eff[WIDTH-1] != in_b[WIDTH-1]) && (dif_w[WIDTH-1] != a_eff[WIDTH-1]);
      end
      4'd2: c_res = a_eff & in_b;
      4'd3: c_res = a_eff | in_b;
      4'd4: c_res = a_eff ^ in_b;
      4'd5: c_res = ~(a_eff ^ in_b);
      4'd6: begin
        c_res = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      4'd7: begin
        c_res = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      4'd8: begin
        c_res = sra_w[WIDTH:1];
        c_c   = sra_w[0];
      end
      4'd9:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a_eff) < $signed(in_b))};
      4'd10: c_res = {{(WIDTH-1){1'b0}}, (a_eff < in_b)};
      4'd11: c_res = in_b;
      default: c_err = 1'b1;
    endcase
    c_flags = c_err ? 4'b0000 : {c_res[WIDTH-1], (c_res == '0), c_c, c_v};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_flags   <= '0;
      s1_err     <= 1'b0;
      s1_tag     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      acc        <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= s1_result;
          out_flags  <= s1_flags;
          out_err    <= s1_err;
          out_tag    <= s1_tag;
        end
      end
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_result <= c_res;
        s1_flags  <= c_flags;
        s1_err    <= c_err;
        s1_tag    <= in_tag;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      // A clear on the same edge as an accumulating op wins; the op still used the old value.
      if (acc_clr) begin
        acc <= '0;
      end else if (accept && in_acc && !c_err) begin
        acc <= c_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe: a driver pushes expected beats into a
// queue from an arithmetic reference model, and a monitor pops and compares on output.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int EW = W + 4 + 1 + TW;
  localparam int M  = 1 << W;
  localparam int H  = M / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_acc = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic          out_err;
  logic [TW-1:0] out_tag;
  logic [W-1:0]  acc_value;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_acc(in_acc), .in_tag(in_tag), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_err(out_err), .out_tag(out_tag), .acc_value(acc_value)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int model_acc = 0;
  bit rdy_force = 1'b1;
  bit rdy_val = 1'b1;
  logic [EW-1:0] exp_q[$];

  always @(negedge clk) out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input int op, input int ua, input int ub,
                                          input int tag, output int r_out, output bit err_out);
    int sa, sb, s, r, t, p, q;
    bit n, z, c, v, err;
    logic [W-1:0] rv;
    logic [TW-1:0] tv;
    sa = (ua >= H) ? ua - M : ua;
    sb = (ub >= H) ? ub - M : ub;
    s = ub % W;
    r = 0; n = 0; z = 0; c = 0; v = 0; err = 0;
    case (op)
      0: begin t = ua + ub; r = t % M; c = (t >= M); v = (sa + sb >= H) || (sa + sb < -H); end
      1: begin t = ua - ub; r = (t + M) % M; c = (ua < ub); v = (sa - sb >= H) || (sa - sb < -H); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (~(ua ^ ub)) & (M - 1);
      6: begin t = ua * (1 << s); r = t % M; c = (s > 0) ? ((t / M) % 2 == 1) : 1'b0; end
      7: begin r = ua / (1 << s); c = (s > 0) ? ((ua / (1 << (s - 1))) % 2 == 1) : 1'b0; end
      8: begin
        p = 1 << s;
        q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        r = (q + M) % M;
        c = (s > 0) ? ((ua / (1 << (s - 1))) % 2 == 1) : 1'b0;
      end
      9:  r = (sa < sb) ? 1 : 0;
      10: r = (ua < ub) ? 1 : 0;
      11: r = ub;
      default: err = 1'b1;
    endcase
    if (!err) begin
      n = (r >= H);
      z = (r == 0);
    end
    r_out = r;
    err_out = err;
    rv = r[W-1:0];
    tv = tag[TW-1:0];
    return {rv, n, z, c, v, err, tv};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int op, input int a, input int b, input bit acc, input int tag,
                      input bit clr, input bit fx_en, input int fx_res, input int fx_flags,
                      input bit fx_err);
    int tries;
    int a_eff, r;
    bit err, done;
    logic [EW-1:0] e;
    logic [W-1:0] fr;
    logic [3:0] ff;
    logic [TW-1:0] ft;
    tries = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op = 4'(op);
      in_a = W'(a);
      in_b = W'(b);
      in_acc = acc;
      in_tag = TW'(tag);
      acc_clr = clr;
      #1;
      a_eff = acc ? model_acc : a;
      if (in_ready) begin
        e = model(op, a_eff, b, tag, r, err);
        if (fx_en) begin
          fr = fx_res[W-1:0];
          ff = fx_flags[3:0];
          ft = tag[TW-1:0];
          e = {fr, ff, fx_err, ft};
        end
        exp_q.push_back(e);
        acc_cnt++;
        done = 1'b1;
        if (clr) model_acc = 0;
        else if (acc && !err) model_acc = r;
      end else begin
        if (clr) model_acc = 0;
        tries++;
        if (tries > 200) begin
          check("send_timeout", 32'(tries), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_clr = 1'b0;
      clr = 1'b0;
      check("acc_value", 32'(acc_value), 32'(model_acc));
    end
  endtask

  task automatic send_rand(input bit allow_acc);
    send($urandom_range(0, 15), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
         allow_acc && ($urandom_range(0, 3) == 0), $urandom_range(0, (1 << TW) - 1),
         allow_acc && ($urandom_range(0, 19) == 0), 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int t;
    rdy_force = 1'b1;
    rdy_val = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit hold_v = 1'b0;
  logic [EW-1:0] held;

  always @(negedge clk) begin
    logic [EW-1:0] act, e;
    #2;
    act = {out_result, out_flags, out_err, out_tag};
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_stable", 32'({out_valid, act}), 32'({1'b1, held}));
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(act), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(act), 32'(e));
        end
      end else if (out_valid) begin
        held = act;
        hold_v = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_acc", 32'(acc_value), 32'd0);
    check("rst_outputs", 32'({out_result, out_flags, out_err, out_tag}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency and the directed operation vectors
    send(0, 8'hFF, 8'h01, 1'b0, 3, 1'b0, 1'b1, 8'h00, 4'b0110, 1'b0);
    check("lat_edge_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge_n1", 32'(out_valid), 32'd1);
    send(1,  8'h80, 8'h01, 1'b0, 1, 1'b0, 1'b1, 8'h7F, 4'b0001, 1'b0);
    send(9,  8'hFE, 8'h01, 1'b0, 2, 1'b0, 1'b1, 8'h01, 4'b0000, 1'b0);
    send(10, 8'hFE, 8'h01, 1'b0, 3, 1'b0, 1'b1, 8'h00, 4'b0100, 1'b0);
    send(8,  8'h90, 8'h0B, 1'b0, 4, 1'b0, 1'b1, 8'hF2, 4'b1000, 1'b0);
    send(6,  8'h81, 8'h01, 1'b0, 5, 1'b0, 1'b1, 8'h02, 4'b0010, 1'b0);
    send(13, 8'h55, 8'h33, 1'b0, 6, 1'b0, 1'b1, 8'h00, 4'b0000, 1'b1);
    drain();

    // Accumulator chain, then clear coinciding with an accumulating op
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    model_acc = 0;
    check("acc_clr", 32'(acc_value), 32'd0);
    send(0, 0, 5, 1'b1, 7, 1'b0, 1'b1, 5,  4'b0000, 1'b0);
    send(0, 0, 5, 1'b1, 8, 1'b0, 1'b1, 10, 4'b0000, 1'b0);
    send(0, 0, 5, 1'b1, 9, 1'b0, 1'b1, 15, 4'b0000, 1'b0);
    check("acc_chain", 32'(acc_value), 32'd15);
    send(0, 0, 5, 1'b1, 10, 1'b1, 1'b1, 20, 4'b0000, 1'b0);
    check("acc_clr_wins", 32'(acc_value), 32'd0);
    drain();

    // Back-pressure: only two beats fit while the sink stalls
    base = acc_cnt;
    rdy_force = 1'b1;
    rdy_val = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom_range(0, 15), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
               1'b0, i, 1'b0, 1'b0, 0, 0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #3;
        check("stall_accepts", 32'(acc_cnt - base), 32'd2);
        rdy_val = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random sink back-pressure
    rdy_force = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand(1'b1);
    end
    drain();

    // Reset with both stages full
    rdy_force = 1'b1;
    rdy_val = 1'b0;
    send(0, 0, 9, 1'b1, 11, 1'b0, 1'b0, 0, 0, 1'b0);
    send(3, 8'h0F, 8'hF0, 1'b0, 12, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    model_acc = 0;
    check("rst_full_out_valid", 32'(out_valid), 32'd0);
    check("rst_full_acc", 32'(acc_value), 32'd0);
    check("rst_full_outputs", 32'({out_result, out_flags, out_err, out_tag}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdy_val = 1'b1;
    for (int i = 0; i < 20; i++) send_rand(1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
